// File: rtl/load_arbiter.sv
// load_arbiter: round-robin arbiter between a control-path and a UART-path
// time-load request. The granted BCD HH:MM time is range-checked for one
// cycle, then either loaded into the counter (o_load) or rejected (o_err).
// An accepted load is followed by HOLDOFF idle cycles before the next grant.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   c_req, c_time   control-path request level and BCD time
//   c_ack           one-cycle pulse, control request captured
//   u_req, u_time   UART-path request level and BCD time
//   u_ack           one-cycle pulse, UART request captured
//   o_time          registered time presented to the counter
//   o_load          one-cycle pulse, counter loads o_time
//   o_err           one-cycle pulse, captured time rejected
//   o_busy          high whenever the arbiter is not idle
module load_arbiter #(
    parameter int unsigned HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [15:0] c_time,
    output logic        c_ack,
    input  logic        u_req,
    input  logic [15:0] u_time,
    output logic        u_ack,
    output logic [15:0] o_time,
    output logic        o_load,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] cand_q, cand_d;
    logic          last_u_q, last_u_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] time_q, time_d;
    logic          c_ack_q, c_ack_d;
    logic          u_ack_q, u_ack_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          grant_u;
    logic          cand_ok;

    logic [3:0] dig3, dig2, dig1, dig0;

    assign dig3 = cand_q[15:12];
    assign dig2 = cand_q[11:8];
    assign dig1 = cand_q[7:4];
    assign dig0 = cand_q[3:0];

    // Valid HH:MM: 00:00 .. 23:59 in BCD
    assign cand_ok = (dig0 <= 4'd9) && (dig1 <= 4'd5) && (dig2 <= 4'd9) &&
                     (dig3 <= 4'd2) && !((dig3 == 4'd2) && (dig2 > 4'd3));

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cand_q   <= '0;
            last_u_q <= 1'b1;
            cnt_q    <= '0;
            time_q   <= '0;
            c_ack_q  <= 1'b0;
            u_ack_q  <= 1'b0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            last_u_q <= last_u_d;
            cnt_q    <= cnt_d;
            time_q   <= time_d;
            c_ack_q  <= c_ack_d;
            u_ack_q  <= u_ack_d;
            load_q   <= load_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        last_u_d = last_u_q;
        cnt_d    = cnt_q;
        time_d   = time_q;
        c_ack_d  = 1'b0;
        u_ack_d  = 1'b0;
        load_d   = 1'b0;
        err_d    = 1'b0;
        grant_u  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (c_req || u_req) begin
                    // UART wins only if alone or if control was granted last
                    grant_u  = u_req && !(c_req && last_u_q);
                    cand_d   = grant_u ? u_time : c_time;
                    last_u_d = grant_u;
                    u_ack_d  = grant_u;
                    c_ack_d  = !grant_u;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cand_ok) begin
                    time_d = cand_q;
                    load_d = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = CW'(HOLDOFF);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                // Counter holds the remaining HOLD cycles including this one
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign c_ack  = c_ack_q;
    assign u_ack  = u_ack_q;
    assign o_time = time_q;
    assign o_load = load_q;
    assign o_err  = err_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_load_arbiter.sv
// Bench for load_arbiter: two instances (HOLDOFF=4 and HOLDOFF=0) driven by
// directed sequences, checked every cycle against an event-schedule model
// plus literal expectations at key points.
module tb_load_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic        a_creq, a_ureq, a_cack, a_uack, a_load, a_err, a_busy;
    logic [15:0] a_ctime, a_utime, a_otime;
    logic        b_creq, b_ureq, b_cack, b_uack, b_load, b_err, b_busy;
    logic [15:0] b_ctime, b_utime, b_otime;

    load_arbiter #(.HOLDOFF(4)) dut_a (
        .clk(clk), .reset(reset),
        .c_req(a_creq), .c_time(a_ctime), .c_ack(a_cack),
        .u_req(a_ureq), .u_time(a_utime), .u_ack(a_uack),
        .o_time(a_otime), .o_load(a_load), .o_err(a_err), .o_busy(a_busy)
    );

    load_arbiter #(.HOLDOFF(0)) dut_b (
        .clk(clk), .reset(reset),
        .c_req(b_creq), .c_time(b_ctime), .c_ack(b_cack),
        .u_req(b_ureq), .u_time(b_utime), .u_ack(b_uack),
        .o_time(b_otime), .o_load(b_load), .o_err(b_err), .o_busy(b_busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: grants, completions and free time as events
    int          m_cyc [2] = '{0, 0};
    int          m_free[2] = '{0, 0};
    int          m_pedge[2];
    bit          m_pend[2];
    bit          m_lastu[2];
    logic [15:0] m_cand[2];
    logic        e_cack[2], e_uack[2], e_load[2], e_err[2], e_busy[2];
    logic [15:0] e_time[2];

    function automatic bit time_ok(input logic [15:0] t);
        int d3, d2, d1, d0;
        d3 = int'(t[15:12]); d2 = int'(t[11:8]); d1 = int'(t[7:4]); d0 = int'(t[3:0]);
        if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return 1'b0;
        return ((d3 * 10 + d2) < 24) && ((d1 * 10 + d0) < 60);
    endfunction

    task automatic model_step(input int k, input int hold, input logic rst,
                              input logic creq, input logic [15:0] ctime,
                              input logic ureq, input logic [15:0] utime);
        int n;
        bit pick_u;
        e_cack[k] = 1'b0; e_uack[k] = 1'b0; e_load[k] = 1'b0; e_err[k] = 1'b0;
        if (rst) begin
            m_pend[k] = 1'b0; m_free[k] = 0; m_lastu[k] = 1'b1;
            e_time[k] = 16'h0000; e_busy[k] = 1'b0;
        end else begin
            n = m_cyc[k];
            m_cyc[k]++;
            if (m_pend[k] && n == m_pedge[k]) begin
                m_pend[k] = 1'b0;
                if (time_ok(m_cand[k])) begin
                    e_load[k] = 1'b1; e_time[k] = m_cand[k]; m_free[k] = n + hold + 1;
                end else begin
                    e_err[k] = 1'b1; m_free[k] = n + 1;
                end
            end else if (!m_pend[k] && n >= m_free[k] && (creq || ureq)) begin
                pick_u = ureq && !(creq && m_lastu[k]);
                m_cand[k] = pick_u ? utime : ctime;
                m_lastu[k] = pick_u;
                e_uack[k] = pick_u; e_cack[k] = !pick_u;
                m_pend[k] = 1'b1; m_pedge[k] = n + 1; m_free[k] = 32'h7fffffff;
            end
            e_busy[k] = m_pend[k] || (m_free[k] > n + 1);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        model_step(0, 4, reset, a_creq, a_ctime, a_ureq, a_utime);
        model_step(1, 0, reset, b_creq, b_ctime, b_ureq, b_utime);
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("a_cack", 16'(a_cack), 16'(e_cack[0]));
        chk("a_uack", 16'(a_uack), 16'(e_uack[0]));
        chk("a_load", 16'(a_load), 16'(e_load[0]));
        chk("a_err",  16'(a_err),  16'(e_err[0]));
        chk("a_busy", 16'(a_busy), 16'(e_busy[0]));
        chk("a_time", a_otime, e_time[0]);
        chk("b_cack", 16'(b_cack), 16'(e_cack[1]));
        chk("b_uack", 16'(b_uack), 16'(e_uack[1]));
        chk("b_load", 16'(b_load), 16'(e_load[1]));
        chk("b_err",  16'(b_err),  16'(e_err[1]));
        chk("b_busy", 16'(b_busy), 16'(e_busy[1]));
        chk("b_time", b_otime, e_time[1]);
    end

    // ---------------- directed stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [15:0] ld[$];
    logic [15:0] bad[2] = '{16'h2400, 16'h1960};
    int bcnt, uat, cat, errs, loads;

    initial begin
        a_creq = 1'b0; a_ureq = 1'b0; a_ctime = '0; a_utime = '0;
        b_creq = 1'b0; b_ureq = 1'b0; b_ctime = '0; b_utime = '0;
        tick();
        tick();
        chk("rst_a_time", a_otime, 16'h0000);
        chk("rst_a_busy", 16'(a_busy), 16'd0);
        reset = 1'b0;
        tick();
        tick();

        // Single control load, HOLDOFF=4
        a_ctime = 16'h1234; a_creq = 1'b1; bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                chk("s1_cack", 16'(a_cack), 16'd1);
                a_creq = 1'b0;
            end
            if (i == 1) begin
                chk("s1_load", 16'(a_load), 16'd1);
                chk("s1_time", a_otime, 16'h1234);
            end
            if (a_busy) bcnt++;
        end
        chk("s1_busy_len", 16'(bcnt), 16'd5);

        // Tie from reset: control first, UART after holdoff
        do_reset();
        a_ctime = 16'h0830; a_utime = 16'h2159; a_creq = 1'b1; a_ureq = 1'b1;
        uat = -1; ld.delete();
        for (int i = 0; i < 14; i++) begin
            tick();
            if (a_cack) a_creq = 1'b0;
            if (a_uack) begin uat = i; a_ureq = 1'b0; end
            if (a_load) ld.push_back(a_otime);
        end
        chk("s2_uack_at", 16'(uat), 16'd6);
        chk("s2_nloads", 16'(ld.size()), 16'd2);
        if (ld.size() >= 2) begin
            chk("s2_first", ld[0], 16'h0830);
            chk("s2_second", ld[1], 16'h2159);
        end

        // Invalid UART times rejected, o_time kept
        foreach (bad[j]) begin
            a_utime = bad[j]; a_ureq = 1'b1; errs = 0; loads = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (a_uack) a_ureq = 1'b0;
                errs += int'(a_err);
                loads += int'(a_load);
            end
            chk("s3_errs", 16'(errs), 16'd1);
            chk("s3_loads", 16'(loads), 16'd0);
            chk("s3_time", a_otime, 16'h2159);
        end

        // UART request raised during HOLD waits for IDLE
        a_ctime = 16'h0945; a_creq = 1'b1; uat = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_cack) a_creq = 1'b0;
            if (i == 2) begin a_utime = 16'h1200; a_ureq = 1'b1; end
            if (a_uack && uat < 0) begin uat = i; a_ureq = 1'b0; end
        end
        chk("s4_uack_at", 16'(uat), 16'd6);
        chk("s4_time", a_otime, 16'h1200);

        // Reset during CHECK aborts the load
        a_ctime = 16'h1545; a_creq = 1'b1;
        tick();
        chk("s5_cack", 16'(a_cack), 16'd1);
        a_creq = 1'b0;
        reset = 1'b1;
        #1;
        chk("s5_busy_rst", 16'(a_busy), 16'd0);
        tick();
        reset = 1'b0;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            loads += int'(a_load);
        end
        chk("s5_loads", 16'(loads), 16'd0);
        chk("s5_time", a_otime, 16'h0000);

        // HOLDOFF=0: back-to-back control then UART
        b_ctime = 16'h0100; b_creq = 1'b1; uat = -1; ld.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b_cack) begin b_creq = 1'b0; b_utime = 16'h0200; b_ureq = 1'b1; end
            if (b_uack) begin uat = i; b_ureq = 1'b0; end
            if (b_load) ld.push_back(b_otime);
        end
        chk("s6_uack_at", 16'(uat), 16'd2);
        chk("s6_nloads", 16'(ld.size()), 16'd2);
        if (ld.size() >= 2) begin
            chk("s6_first", ld[0], 16'h0100);
            chk("s6_second", ld[1], 16'h0200);
        end

        // HOLDOFF=0 tie after a UART grant: control wins, boundary 23:59
        b_ctime = 16'h0001; b_utime = 16'h2359; b_creq = 1'b1; b_ureq = 1'b1;
        cat = -1; uat = -1; ld.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b_cack) begin cat = i; b_creq = 1'b0; end
            if (b_uack) begin uat = i; b_ureq = 1'b0; end
            if (b_load) ld.push_back(b_otime);
        end
        chk("s7_cack_at", 16'(cat), 16'd0);
        chk("s7_uack_at", 16'(uat), 16'd2);
        if (ld.size() >= 2) chk("s7_second", ld[1], 16'h2359);

        // Non-BCD digit rejected
        b_utime = 16'h0A00; b_ureq = 1'b1; errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b_uack) b_ureq = 1'b0;
            errs += int'(b_err);
        end
        chk("s8_errs", 16'(errs), 16'd1);
        chk("s8_time", b_otime, 16'h2359);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
